hsi_m_poll_sched: RTL and testbench

- Master-side transaction scheduler for the HSI link.
- Issues periodic poll frames to the TX path and waits for the reply from the RX control chain (decoder, error check, CRC).
- Checks the reply's error flags and times out missing replies; retries failed transactions and alternates the receive line (dat_src) between dat1 and dat2 for redundancy.
- Drives sdreq_en so that a slave's service request is followed by a service-data request frame.

---
 rtl/hsi_pkg.sv | 27 ++
 rtl/hsi_m_poll_sched_if.sv | 21 ++
 rtl/hsi_tick_cnt.sv | 25 ++
 rtl/hsi_m_poll_sched.sv | 153 +++++++++++++++
 tb/tb_hsi_m_poll_sched.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hsi_pkg.sv
// Shared types and default timing for the HSI master poll scheduler.
package hsi_pkg;

  localparam int unsigned RX_ERR_W       = 6;
  localparam int unsigned RX_TIMEOUT_DEF = 64;
  localparam int unsigned POLL_GAP_DEF   = 16;
  localparam int unsigned MAX_RETRY_DEF  = 3;
  localparam int unsigned CNT_W_DEF      = 8;
  localparam int unsigned RETRY_W        = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_TX_WAIT = 3'd2,
    ST_RX_WAIT = 3'd3,
    ST_EVAL    = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  // Reply fields latched at rx_frame_end and evaluated one cycle later.
  typedef struct packed {
    logic [RX_ERR_W-1:0] errs;
    logic                service_req;
    logic                sd_busy;
  } rx_reply_t;

endpackage

// File: rtl/hsi_m_poll_sched_if.sv
// TX request / RX reply handshake between the poll scheduler and the link datapath.
interface hsi_m_poll_sched_if;

  logic                         tx_start;
  logic                         tx_done;
  logic                         rx_frame_end;
  logic [hsi_pkg::RX_ERR_W-1:0] rx_errs;
  logic                         rx_service_req;
  logic                         rx_sd_busy;

  modport master (
    output tx_start,
    input  tx_done, rx_frame_end, rx_errs, rx_service_req, rx_sd_busy
  );

  modport slave (
    input  tx_start,
    output tx_done, rx_frame_end, rx_errs, rx_service_req, rx_sd_busy
  );

endinterface

// File: rtl/hsi_tick_cnt.sv
// Tick-gated up-counter with clear; stops at the limit so it can never wrap.
module hsi_tick_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt;

  assign done_c = (cnt >= limit);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick && !done_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hsi_m_poll_sched.sv
// HSI master transaction scheduler: periodic polls, reply check/timeout,
// retry with dat1/dat2 line alternation and service-data request sequencing.
module hsi_m_poll_sched
  import hsi_pkg::*;
#(
  parameter int unsigned RX_TIMEOUT = RX_TIMEOUT_DEF,
  parameter int unsigned POLL_GAP   = POLL_GAP_DEF,
  parameter int unsigned MAX_RETRY  = MAX_RETRY_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  poll_en,
  hsi_m_poll_sched_if.master    bus,
  output logic                  dat_src,
  output logic                  sdreq_en,
  output logic                  busy,
  output logic                  trans_ok,
  output logic                  trans_fail,
  output logic                  timeout,
  output logic [RX_ERR_W-1:0]   last_errs,
  output logic                  link_fail,
  output logic [RETRY_W-1:0]    retry_cnt
);

  state_t             state, state_d;
  rx_reply_t          reply_q, reply_d;
  logic               to_q, to_d;
  logic               tx_start_q, tx_start_d;
  logic               dat_src_d, sdreq_d, busy_d;
  logic               trans_ok_d, trans_fail_d, timeout_d, link_fail_d;
  logic [RETRY_W-1:0] retry_d;

  logic               cnt_clr_c, cnt_done_c;
  logic [CNT_W-1:0]   cnt_limit_c;

  // One counter serves both the reply timeout and the inter-poll gap.
  assign cnt_clr_c   = !((state == ST_RX_WAIT) || (state == ST_GAP));
  assign cnt_limit_c = (state == ST_GAP) ? CNT_W'(POLL_GAP) : CNT_W'(RX_TIMEOUT);

  hsi_tick_cnt #(.CNT_W(CNT_W)) u_tick_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_c),
    .tick   (clk_en),
    .limit  (cnt_limit_c),
    .done_c (cnt_done_c)
  );

  assign bus.tx_start = tx_start_q;
  assign last_errs    = reply_q.errs;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    reply_d      = reply_q;
    to_d         = to_q;
    dat_src_d    = dat_src;
    sdreq_d      = sdreq_en;
    retry_d      = retry_cnt;
    link_fail_d  = link_fail;
    trans_ok_d   = 1'b0;
    trans_fail_d = 1'b0;
    timeout_d    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (poll_en) begin
          state_d     = ST_START;
          link_fail_d = 1'b0;
        end
      end
      ST_START: state_d = ST_TX_WAIT;
      ST_TX_WAIT: begin
        if (bus.tx_done) state_d = ST_RX_WAIT;
      end
      ST_RX_WAIT: begin
        // A frame ending in the expiry cycle still counts as a reply.
        if (bus.rx_frame_end) begin
          reply_d.errs        = bus.rx_errs;
          reply_d.service_req = bus.rx_service_req;
          reply_d.sd_busy     = bus.rx_sd_busy;
          to_d                = 1'b0;
          state_d             = ST_EVAL;
        end else if (cnt_done_c) begin
          to_d    = 1'b1;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (!to_q && (reply_q.errs == '0)) begin
          trans_ok_d = 1'b1;
          retry_d    = '0;
          sdreq_d    = reply_q.service_req & ~reply_q.sd_busy;
        end else begin
          trans_fail_d = 1'b1;
          timeout_d    = to_q;
          dat_src_d    = ~dat_src;
          if (retry_cnt < RETRY_W'(MAX_RETRY)) retry_d = retry_cnt + RETRY_W'(1);
          if (retry_d >= RETRY_W'(MAX_RETRY)) link_fail_d = 1'b1;
        end
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_done_c) begin
          if (poll_en) begin
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
            sdreq_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tx_start_d = (state == ST_START);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      reply_q    <= '0;
      to_q       <= 1'b0;
      tx_start_q <= 1'b0;
      dat_src    <= 1'b1;
      sdreq_en   <= 1'b0;
      busy       <= 1'b0;
      trans_ok   <= 1'b0;
      trans_fail <= 1'b0;
      timeout    <= 1'b0;
      link_fail  <= 1'b0;
      retry_cnt  <= '0;
    end else begin
      state      <= state_d;
      reply_q    <= reply_d;
      to_q       <= to_d;
      tx_start_q <= tx_start_d;
      dat_src    <= dat_src_d;
      sdreq_en   <= sdreq_d;
      busy       <= busy_d;
      trans_ok   <= trans_ok_d;
      trans_fail <= trans_fail_d;
      timeout    <= timeout_d;
      link_fail  <= link_fail_d;
      retry_cnt  <= retry_d;
    end
  end

endmodule

// File: tb/tb_hsi_m_poll_sched.sv
// Directed bench for hsi_m_poll_sched with hand-computed cycle expectations.
module tb_hsi_m_poll_sched;

  logic       clk = 1'b0;
  logic       rst, clk_en, poll_en;
  logic       dat_src, sdreq_en, busy, trans_ok, trans_fail, timeout, link_fail;
  logic [5:0] last_errs;
  logic [1:0] retry_cnt;
  int         n_checks = 0;
  int         n_pass   = 0;

  hsi_m_poll_sched_if bus();

  hsi_m_poll_sched dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .poll_en    (poll_en),
    .bus        (bus),
    .dat_src    (dat_src),
    .sdreq_en   (sdreq_en),
    .busy       (busy),
    .trans_ok   (trans_ok),
    .trans_fail (trans_fail),
    .timeout    (timeout),
    .last_errs  (last_errs),
    .link_fail  (link_fail),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.tx_start === 1'b1) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic send_tx_done(input int dly);
    repeat (dly) step();
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
  endtask

  task automatic send_reply(input int dly, input logic [5:0] e, input logic s, input logic b);
    repeat (dly) step();
    bus.rx_frame_end   = 1'b1;
    bus.rx_errs        = e;
    bus.rx_service_req = s;
    bus.rx_sd_busy     = b;
    step();
    bus.rx_frame_end   = 1'b0;
    bus.rx_errs        = '0;
    bus.rx_service_req = 1'b0;
    bus.rx_sd_busy     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (bus.tx_start !== 1'b0) $display("FAIL rst_tx_start: got %b want 0", bus.tx_start); else n_pass++;
    n_checks++; if (dat_src !== 1'b1) $display("FAIL rst_dat_src: got %b want 1", dat_src); else n_pass++;
    n_checks++; if ({trans_ok, trans_fail, timeout, link_fail, sdreq_en} !== 5'b0)
      $display("FAIL rst_flags: got %b want 00000", {trans_ok, trans_fail, timeout, link_fail, sdreq_en}); else n_pass++;
    n_checks++; if ({retry_cnt, last_errs} !== 8'h00) $display("FAIL rst_cnt_errs: got %h want 00", {retry_cnt, last_errs}); else n_pass++;
    rst = 1'b0;
    repeat (3) step();
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_clean_poll();
    int cyc;
    poll_en = 1'b1;
    step();
    n_checks++; if (bus.tx_start !== 1'b0) $display("FAIL start_lat1: got %b want 0", bus.tx_start); else n_pass++;
    step();
    n_checks++; if (bus.tx_start !== 1'b1) $display("FAIL start_lat2: got %b want 1", bus.tx_start); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL clean_busy: got %b want 1", busy); else n_pass++;
    send_tx_done(20);
    send_reply(10, 6'b0, 1'b0, 1'b0);
    n_checks++; if (trans_ok !== 1'b0) $display("FAIL ok_lat1: got %b want 0", trans_ok); else n_pass++;
    step();
    n_checks++; if (trans_ok !== 1'b1) $display("FAIL clean_ok: got %b want 1", trans_ok); else n_pass++;
    n_checks++; if (trans_fail !== 1'b0) $display("FAIL clean_fail: got %b want 0", trans_fail); else n_pass++;
    n_checks++; if (dat_src !== 1'b1) $display("FAIL clean_dat_src: got %b want 1", dat_src); else n_pass++;
    n_checks++; if (retry_cnt !== 2'd0) $display("FAIL clean_retry: got %0d want 0", retry_cnt); else n_pass++;
    step();
    cyc = 1;
    n_checks++; if (trans_ok !== 1'b0) $display("FAIL ok_width: got %b want 0", trans_ok); else n_pass++;
    while (bus.tx_start !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    n_checks++; if (cyc != 18) $display("FAIL gap_cycles: got %0d want 18", cyc); else n_pass++;
  endtask

  task automatic test_timeout();
    int cyc = 0;
    bit ok;
    send_tx_done(20);
    while (trans_fail !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    n_checks++; if (cyc != 66) $display("FAIL to_cycles: got %0d want 66", cyc); else n_pass++;
    n_checks++; if (timeout !== 1'b1) $display("FAIL to_pulse: got %b want 1", timeout); else n_pass++;
    n_checks++; if (trans_ok !== 1'b0) $display("FAIL to_ok: got %b want 0", trans_ok); else n_pass++;
    n_checks++; if (dat_src !== 1'b0) $display("FAIL to_dat_src: got %b want 0", dat_src); else n_pass++;
    n_checks++; if (retry_cnt !== 2'd1) $display("FAIL to_retry: got %0d want 1", retry_cnt); else n_pass++;
    n_checks++; if (last_errs !== 6'h00) $display("FAIL to_last_errs: got %h want 00", last_errs); else n_pass++;
    wait_tx_start(ok);
    n_checks++; if (!ok) $display("FAIL to_next_start: got none want tx_start"); else n_pass++;
    send_tx_done(5);
    send_reply(3, 6'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (trans_ok !== 1'b1) $display("FAIL rec_ok: got %b want 1", trans_ok); else n_pass++;
    n_checks++; if (retry_cnt !== 2'd0) $display("FAIL rec_retry: got %0d want 0", retry_cnt); else n_pass++;
    n_checks++; if (dat_src !== 1'b0) $display("FAIL rec_dat_src: got %b want 0", dat_src); else n_pass++;
  endtask

  task automatic test_err_escalation();
    logic       exp_dat[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] exp_retry[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic       exp_lf[4]    = '{1'b0, 1'b0, 1'b1, 1'b1};
    bit ok;
    for (int i = 0; i < 4; i++) begin
      wait_tx_start(ok);
      n_checks++; if (!ok) $display("FAIL err_start[%0d]: got none want tx_start", i); else n_pass++;
      send_tx_done(4);
      send_reply(6, 6'b000100, 1'b0, 1'b0);
      step();
      n_checks++; if ({trans_fail, timeout} !== 2'b10) $display("FAIL err_fail[%0d]: got %b want 10", i, {trans_fail, timeout}); else n_pass++;
      n_checks++; if (dat_src !== exp_dat[i]) $display("FAIL err_dat[%0d]: got %b want %b", i, dat_src, exp_dat[i]); else n_pass++;
      n_checks++; if (retry_cnt !== exp_retry[i]) $display("FAIL err_retry[%0d]: got %0d want %0d", i, retry_cnt, exp_retry[i]); else n_pass++;
      n_checks++; if (link_fail !== exp_lf[i]) $display("FAIL err_link_fail[%0d]: got %b want %b", i, link_fail, exp_lf[i]); else n_pass++;
      n_checks++; if (last_errs !== 6'b000100) $display("FAIL err_last[%0d]: got %h want 04", i, last_errs); else n_pass++;
    end
    wait_tx_start(ok);
    send_tx_done(4);
    send_reply(6, 6'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (trans_ok !== 1'b1) $display("FAIL lf_poll_ok: got %b want 1", trans_ok); else n_pass++;
    n_checks++; if (retry_cnt !== 2'd0) $display("FAIL lf_retry: got %0d want 0", retry_cnt); else n_pass++;
    n_checks++; if (link_fail !== 1'b1) $display("FAIL lf_sticky: got %b want 1", link_fail); else n_pass++;
  endtask

  task automatic test_service_req();
    bit ok;
    wait_tx_start(ok);
    send_tx_done(4);
    send_reply(2, 6'b0, 1'b1, 1'b0);
    step();
    n_checks++; if ({trans_ok, sdreq_en} !== 2'b11) $display("FAIL sr_set: got %b want 11", {trans_ok, sdreq_en}); else n_pass++;
    wait_tx_start(ok);
    n_checks++; if (sdreq_en !== 1'b1) $display("FAIL sr_frame: got %b want 1", sdreq_en); else n_pass++;
    send_tx_done(4);
    send_reply(2, 6'b000001, 1'b0, 1'b0);
    step();
    n_checks++; if ({trans_fail, sdreq_en} !== 2'b11) $display("FAIL sr_retry_hold: got %b want 11", {trans_fail, sdreq_en}); else n_pass++;
    wait_tx_start(ok);
    n_checks++; if (sdreq_en !== 1'b1) $display("FAIL sr_retry_frame: got %b want 1", sdreq_en); else n_pass++;
    send_tx_done(4);
    send_reply(2, 6'b0, 1'b1, 1'b1);
    step();
    n_checks++; if ({trans_ok, sdreq_en} !== 2'b10) $display("FAIL sr_busy: got %b want 10", {trans_ok, sdreq_en}); else n_pass++;
  endtask

  task automatic test_boundary_same_cycle();
    bit ok;
    wait_tx_start(ok);
    send_tx_done(4);
    send_reply(64, 6'b0, 1'b0, 1'b0);
    step();
    n_checks++; if ({trans_ok, trans_fail, timeout} !== 3'b100)
      $display("FAIL edge_frame_wins: got %b want 100", {trans_ok, trans_fail, timeout}); else n_pass++;
  endtask

  task automatic test_stale_frame();
    int cyc = 0;
    bit ok;
    wait_tx_start(ok);
    repeat (3) step();
    send_reply(0, 6'h3F, 1'b0, 1'b0);
    send_tx_done(10);
    while (trans_fail !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    n_checks++; if (cyc != 66) $display("FAIL stale_cycles: got %0d want 66", cyc); else n_pass++;
    n_checks++; if (timeout !== 1'b1) $display("FAIL stale_timeout: got %b want 1", timeout); else n_pass++;
    n_checks++; if (last_errs !== 6'h00) $display("FAIL stale_last: got %h want 00", last_errs); else n_pass++;
    n_checks++; if (dat_src !== 1'b0) $display("FAIL stale_dat_src: got %b want 0", dat_src); else n_pass++;
  endtask

  task automatic test_poll_drop();
    int cyc = 0;
    bit ok;
    bit seen_start = 1'b0;
    wait_tx_start(ok);
    send_tx_done(4);
    repeat (2) step();
    poll_en = 1'b0;
    send_reply(2, 6'b0, 1'b1, 1'b0);
    step();
    n_checks++; if ({trans_ok, busy, sdreq_en} !== 3'b111) $display("FAIL drop_ok: got %b want 111", {trans_ok, busy, sdreq_en}); else n_pass++;
    while (busy !== 1'b0 && cyc < 100) begin
      step();
      cyc++;
      if (bus.tx_start === 1'b1) seen_start = 1'b1;
    end
    n_checks++; if (cyc != 17) $display("FAIL drop_idle_cycles: got %0d want 17", cyc); else n_pass++;
    n_checks++; if (seen_start) $display("FAIL drop_no_start: got tx_start want none"); else n_pass++;
    n_checks++; if (sdreq_en !== 1'b0) $display("FAIL drop_sdreq: got %b want 0", sdreq_en); else n_pass++;
    repeat (5) step();
    n_checks++; if ({busy, bus.tx_start} !== 2'b00) $display("FAIL drop_stay_idle: got %b want 00", {busy, bus.tx_start}); else n_pass++;
  endtask

  task automatic test_clk_en_gating();
    int cyc = 0;
    n_checks++; if (link_fail !== 1'b1) $display("FAIL ce_lf_before: got %b want 1", link_fail); else n_pass++;
    poll_en = 1'b1;
    step();
    n_checks++; if (link_fail !== 1'b0) $display("FAIL ce_lf_clear: got %b want 0", link_fail); else n_pass++;
    step();
    n_checks++; if (bus.tx_start !== 1'b1) $display("FAIL ce_start: got %b want 1", bus.tx_start); else n_pass++;
    send_tx_done(4);
    send_reply(2, 6'b0, 1'b1, 1'b0);
    step();
    n_checks++; if (trans_ok !== 1'b1) $display("FAIL ce_ok: got %b want 1", trans_ok); else n_pass++;
    while (bus.tx_start !== 1'b1 && cyc < 100) begin
      cyc++;
      clk_en = (cyc % 2 == 0);
      step();
    end
    clk_en = 1'b1;
    n_checks++; if (cyc != 34) $display("FAIL ce_gap_cycles: got %0d want 34", cyc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic exp_dat[2] = '{1'b1, 1'b0};
    bit ok;
    bit seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_tx_start(ok);
      send_tx_done(4);
      send_reply(3, 6'b101000, 1'b0, 1'b0);
      step();
      n_checks++; if (dat_src !== exp_dat[i]) $display("FAIL pre_rst_dat[%0d]: got %b want %b", i, dat_src, exp_dat[i]); else n_pass++;
    end
    n_checks++; if ({retry_cnt, last_errs, sdreq_en} !== {2'd2, 6'b101000, 1'b1})
      $display("FAIL pre_rst_state: got %h want %h", {retry_cnt, last_errs, sdreq_en}, {2'd2, 6'b101000, 1'b1}); else n_pass++;
    wait_tx_start(ok);
    send_tx_done(4);
    repeat (5) step();
    rst = 1'b1;
    poll_en = 1'b0;
    step();
    rst = 1'b0;
    n_checks++; if ({busy, bus.tx_start, trans_ok, trans_fail, timeout} !== 5'b0)
      $display("FAIL mid_rst_flags: got %b want 00000", {busy, bus.tx_start, trans_ok, trans_fail, timeout}); else n_pass++;
    n_checks++; if ({dat_src, sdreq_en, link_fail} !== 3'b100) $display("FAIL mid_rst_ctrl: got %b want 100", {dat_src, sdreq_en, link_fail}); else n_pass++;
    n_checks++; if ({retry_cnt, last_errs} !== 8'h00) $display("FAIL mid_rst_cnt_errs: got %h want 00", {retry_cnt, last_errs}); else n_pass++;
    send_reply(2, 6'h3F, 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) begin
      if (trans_ok === 1'b1 || trans_fail === 1'b1 || busy === 1'b1) seen = 1'b1;
      step();
    end
    n_checks++; if (seen) $display("FAIL mid_rst_no_pulse: got activity want none"); else n_pass++;
    n_checks++; if (last_errs !== 6'h00) $display("FAIL mid_rst_ignore_frame: got %h want 00", last_errs); else n_pass++;
  endtask

  initial begin
    rst                = 1'b1;
    clk_en             = 1'b1;
    poll_en            = 1'b0;
    bus.tx_done        = 1'b0;
    bus.rx_frame_end   = 1'b0;
    bus.rx_errs        = '0;
    bus.rx_service_req = 1'b0;
    bus.rx_sd_busy     = 1'b0;
    test_reset();
    test_clean_poll();
    test_timeout();
    test_err_escalation();
    test_service_req();
    test_boundary_same_cycle();
    test_stale_frame();
    test_poll_drop();
    test_clk_en_gating();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
